// File: rtl/mac_arb_pkg.sv
// mac_arb_pkg: FSM encoding, ID-width helper and default watchdog limit for mac_arbiter
package mac_arb_pkg;
   typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_DONE, RESULT} state_t;
   localparam int WDOG_CYC_DEF = 256;
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the slot after ptr
module rr_arbiter
   import mac_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int IW = id_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] j;
   // walk from lowest to highest priority so the nearest requester wins last
   always_comb begin
      gnt = '0;
      idx = '0;
      j = '0;
      for (int k = N; k >= 1; k--) begin
         j = IW'((int'(ptr) + k) % N);
         if (req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            idx = j;
         end
      end
   end
endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin front end sharing one MAC among N_REQ streams and returning its result.
// Define MAC_ARB_WDOG_EN to add the idle-stream watchdog that forces a zero-operand last beat.
module mac_arbiter
   import mac_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_REQ = 4,
   parameter int WDOG_CYC = WDOG_CYC_DEF,
   localparam int IW = id_w(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   auth_done,
   input  logic [N_REQ-1:0]       s_tvalid,
   input  logic [N_REQ-1:0]       s_tlast,
   input  logic [N_REQ*WIDTH-1:0] s_tdata,
   input  logic [N_REQ*WIDTH-1:0] s_weight,
   output logic [N_REQ-1:0]       s_tready,
   output logic                   mac_start,
   output logic                   mac_tlast,
   output logic [WIDTH-1:0]       mac_tdata,
   output logic [WIDTH-1:0]       mac_weight,
   input  logic                   mac_tready,
   input  logic                   mac_done,
   input  logic [2*WIDTH-1:0]     mac_result,
   output logic                   res_valid,
   output logic                   res_err,
   output logic [2*WIDTH-1:0]     res_data,
   output logic [IW-1:0]          res_id,
   input  logic                   res_ready,
   output logic                   busy,
   output logic [IW-1:0]          grant_id
);
   state_t state, state_nx;
   logic [IW-1:0] ptr, rr_idx;
   logic [N_REQ-1:0] rr_gnt;
   logic start_q, vld, fire, grant;
   rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (.req(s_tvalid), .ptr(ptr), .gnt(rr_gnt), .idx(rr_idx));
   assign vld = s_tvalid[grant_id];
   assign grant = state == IDLE && auth_done && |rr_gnt;
   assign mac_start = start_q;
   assign mac_tlast = state == STREAM && ((vld && s_tlast[grant_id]) || fire);
   assign busy = state != IDLE;
   assign res_valid = state == RESULT;
`ifdef MAC_ARB_WDOG_EN
   localparam int CW = $clog2(WDOG_CYC + 1);
   logic [CW-1:0] wd_cnt;
   logic err_q;
   assign fire = state == STREAM && !vld && wd_cnt == CW'(WDOG_CYC);
   assign res_err = res_valid && err_q;
   always_ff @(posedge clk) begin
      wd_cnt <= (!rst_n || state != STREAM || vld) ? '0 : fire ? wd_cnt : wd_cnt + 1'b1;
      err_q <= (!rst_n || state == IDLE) ? 1'b0 : (fire && mac_tready) ? 1'b1 : err_q;
   end
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYC;
   assign fire = 1'b0;
   assign res_err = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      state_nx = grant ? START : IDLE;
         START:     state_nx = mac_tready ? STREAM : START;
         STREAM:    state_nx = (mac_tlast && mac_tready) ? WAIT_DONE : STREAM;
         WAIT_DONE: state_nx = mac_done ? RESULT : WAIT_DONE;
         RESULT:    state_nx = res_ready ? IDLE : RESULT;
         default:   state_nx = IDLE;
      endcase
   end
   // the MAC accumulates every cycle, so idle stream cycles must present zero operands
   always_comb begin
      s_tready = '0;
      mac_tdata = '0;
      mac_weight = '0;
      if (state == STREAM) begin
         s_tready[grant_id] = mac_tready;
         mac_tdata = vld ? s_tdata[int'(grant_id)*WIDTH +: WIDTH] : '0;
         mac_weight = vld ? s_weight[int'(grant_id)*WIDTH +: WIDTH] : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         start_q <= 1'b0;
         grant_id <= '0;
         ptr <= IW'(N_REQ - 1);
         res_data <= '0;
         res_id <= '0;
      end else begin
         state <= state_nx;
         start_q <= grant;
         if (grant) grant_id <= rr_idx;
         if (state == WAIT_DONE && mac_done) begin
            res_data <= mac_result;
            res_id <= grant_id;
         end
         if (state == RESULT && res_ready) ptr <= grant_id;
      end
   end
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: directed checks of mac_arbiter against a simple accumulating MAC responder
module tb_mac_arbiter;
   logic clk = 1'b0;
   logic rst_n, auth_done, mac_tready, mac_done, res_ready;
   logic [3:0] s_tvalid, s_tlast, s_tready;
   logic [63:0] s_tdata, s_weight;
   logic mac_start, mac_tlast, res_valid, res_err, busy;
   logic [15:0] mac_tdata, mac_weight;
   logic [31:0] mac_result, res_data, acc;
   logic [1:0] res_id, grant_id;
   int total = 0, bad = 0, n_start = 0;
   logic ovl = 1'b0;
   logic [1:0] gq[$];

   mac_arbiter #(.WIDTH(16), .N_REQ(4), .WDOG_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .auth_done(auth_done),
      .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata), .s_weight(s_weight),
      .s_tready(s_tready), .mac_start(mac_start), .mac_tlast(mac_tlast),
      .mac_tdata(mac_tdata), .mac_weight(mac_weight), .mac_tready(mac_tready),
      .mac_done(mac_done), .mac_result(mac_result), .res_valid(res_valid),
      .res_err(res_err), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // MAC responder: clears on start, accumulates every ready cycle, pulses done after tlast
   always @(posedge clk) begin
      if (!rst_n || mac_start) acc <= '0;
      else if (mac_tready) acc <= acc + mac_tdata * mac_weight;
      mac_done <= rst_n && mac_tlast && mac_tready;
   end
   assign mac_result = acc;

   always @(posedge clk) if (rst_n && mac_start) begin
      n_start++;
      gq.push_back(grant_id);
   end
   always @(negedge clk) if ($countones(s_tready) > 1) ovl = 1'b1;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic beat(input int r, input logic [15:0] d, input logic [15:0] w, input logic l);
      s_tvalid[r] = 1'b1;
      s_tlast[r] = l;
      s_tdata[r*16 +: 16] = d;
      s_weight[r*16 +: 16] = w;
      #1;
      for (int i = 0; i < 50 && !s_tready[r]; i++) tick();
      chk("beat_ready", s_tready[r], 1);
      tick();
   endtask

   task automatic wait_result(input string tag, input logic [31:0] d, input logic [1:0] id, input logic err);
      for (int i = 0; i < 100 && !res_valid; i++) tick();
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_data"}, res_data, d);
      chk({tag, "_id"}, res_id, id);
      chk({tag, "_err"}, res_err, err);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      int b, n0;
      rst_n = 1'b0; auth_done = 1'b0; mac_tready = 1'b0; res_ready = 1'b0;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_weight = '0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_start", mac_start, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_grant", grant_id, 0);
      // single requester, START held by mac_tready low
      rst_n = 1'b1; auth_done = 1'b1;
      n0 = n_start;
      s_tvalid[0] = 1'b1; s_tdata[15:0] = 16'd2; s_weight[15:0] = 16'd3;
      tick();
      chk("start_pulse", mac_start, 1);
      chk("start_grant", grant_id, 0);
      chk("start_busy", busy, 1);
      tick();
      chk("start_once", mac_start, 0);
      chk("start_no_ready", s_tready, 0);
      mac_tready = 1'b1;
      tick();
      chk("stream_tready", s_tready, 4'b0001);
      chk("stream_tdata", mac_tdata, 2);
      beat(0, 2, 3, 0);
      beat(0, 4, 5, 0);
      s_tlast[0] = 1'b1; s_tdata[15:0] = 16'd1; s_weight[15:0] = 16'd7;
      #1;
      chk("tlast_out", mac_tlast, 1);
      chk("tweight_out", mac_weight, 7);
      beat(0, 1, 7, 1);
      s_tvalid[0] = 1'b0;
      chk("wait_tlast_low", mac_tlast, 0);
      wait_result("single", 33, 0, 0);
      chk("single_starts", n_start - n0, 1);
      chk("single_idle", busy, 0);
      // three continuous requesters from reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      b = gq.size();
      for (int r = 0; r < 3; r++) begin
         s_tvalid[r] = 1'b1; s_tlast[r] = 1'b1;
         s_tdata[r*16 +: 16] = 16'(r + 1); s_weight[r*16 +: 16] = 16'(r + 1);
      end
      wait_result("rr0", 1, 0, 0);
      wait_result("rr1", 4, 1, 0);
      wait_result("rr2", 9, 2, 0);
      wait_result("rr3", 1, 0, 0);
      rst_n = 1'b0; s_tvalid = '0; s_tlast = '0;
      tick();
      rst_n = 1'b1;
      chk("rr_count", gq.size() - b, 4);
      chk("rr_order", {gq[b], gq[b+1], gq[b+2], gq[b+3]}, 8'b00_01_10_00);
      chk("rr_overlap", ovl, 0);
      // gaps mid-stream drive zero operands
      beat(1, 10, 10, 0);
      s_tvalid[1] = 1'b0;
      #1;
      chk("gap_tdata", mac_tdata, 0);
      chk("gap_weight", mac_weight, 0);
      chk("gap_tready", s_tready, 4'b0010);
      repeat (3) tick();
      beat(1, 1, 1, 1);
      s_tvalid[1] = 1'b0;
      wait_result("gap", 101, 1, 0);
      // result held while res_ready is low
      beat(2, 3, 4, 1);
      s_tvalid[2] = 1'b0;
      for (int i = 0; i < 20 && !res_valid; i++) tick();
      n0 = n_start;
      s_tvalid[0] = 1'b1; s_tlast[0] = 1'b1; s_tdata[15:0] = 16'd5; s_weight[15:0] = 16'd5;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", res_valid, 1);
         chk("hold_data", res_data, 12);
         chk("hold_id", res_id, 2);
         tick();
      end
      chk("hold_no_grant", n_start - n0, 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("hs_idle", busy, 0);
      tick();
      chk("hs_next_start", mac_start, 1);
      chk("hs_next_grant", grant_id, 0);
      beat(0, 5, 5, 1);
      s_tvalid[0] = 1'b0;
      wait_result("after_hold", 25, 0, 0);
      // auth_done gates new grants but not a running job
      auth_done = 1'b0;
      n0 = n_start;
      s_tvalid[3] = 1'b1; s_tlast[3] = 1'b1; s_tdata[63:48] = 16'd2; s_weight[63:48] = 16'd2;
      repeat (3) tick();
      chk("noauth_busy", busy, 0);
      chk("noauth_start", n_start - n0, 0);
      auth_done = 1'b1;
      tick();
      chk("auth_start", mac_start, 1);
      chk("auth_grant", grant_id, 3);
      auth_done = 1'b0;
      beat(3, 2, 2, 1);
      s_tvalid[3] = 1'b0;
      wait_result("auth_drop", 4, 3, 0);
      auth_done = 1'b1;
`ifdef MAC_ARB_WDOG_EN
      beat(0, 3, 3, 0);
      s_tvalid[0] = 1'b0;
      wait_result("wdog", 9, 0, 1);
`endif
      // reset while streaming
      beat(2, 7, 7, 0);
      chk("pre_rst_grant", grant_id, 2);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_tready", s_tready, 0);
      chk("mid_rst_start", mac_start, 0);
      chk("mid_rst_tlast", mac_tlast, 0);
      chk("mid_rst_tdata", mac_tdata, 0);
      chk("mid_rst_weight", mac_weight, 0);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_res_err", res_err, 0);
      chk("mid_rst_res_data", res_data, 0);
      chk("mid_rst_res_id", res_id, 0);
      chk("mid_rst_grant", grant_id, 0);
      rst_n = 1'b1; s_tvalid = '0;
      repeat (3) tick();
      chk("post_rst_no_result", res_valid, 0);
      chk("post_rst_idle", busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (matches the MAC datapath).
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter WDOG_CYC, default 256, watchdog idle-cycle limit.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port auth_done  in  1  authentication complete; new grants are allowed only when it is high.
REQ-007 SHALL have ports s_tvalid/s_tlast  in  N_REQ  per-requester beat valid / last beat.
REQ-008 SHALL have ports s_tdata/s_weight  in  N_REQ*WIDTH  per-requester operands; requester i uses slice i.
REQ-009 SHALL have port s_tready  out  N_REQ  per-requester ready; one-hot or zero.
REQ-010 SHALL have ports mac_start/mac_tlast  out  1  MAC start pulse / last beat.
REQ-011 SHALL have ports mac_tdata/mac_weight  out  WIDTH  MAC operands.
REQ-012 SHALL have ports mac_tready/mac_done  in  1  MAC ready / MAC done.
REQ-013 SHALL have port mac_result  in  2*WIDTH  MAC accumulated result.
REQ-014 SHALL have ports res_valid/res_err  out  1, res_data  out  2*WIDTH, res_id  out  clog2(N_REQ)  result channel; res_ready  in  1.
REQ-015 SHALL have ports busy  out  1 and grant_id  out  clog2(N_REQ)  status.

Function
REQ-016 SHALL implement FSM IDLE -> START -> STREAM -> WAIT_DONE -> RESULT -> IDLE.
REQ-017 IDLE: when auth_done=1 and any s_tvalid is high, SHALL grant one requester by round-robin, register grant_id, and enter START.
REQ-018 Round-robin priority SHALL start at the index after the last granted requester; the first grant after reset SHALL favour index 0.
REQ-019 START: SHALL assert mac_start for exactly one cycle, then hold it low, and enter STREAM when mac_tready=1.
REQ-020 STREAM: s_tready[grant_id] SHALL equal mac_tready; all other s_tready bits SHALL be 0.
REQ-021 STREAM: mac_tdata/mac_weight SHALL carry the granted slice when s_tvalid[grant_id]=1, else 0, because the MAC accumulates every cycle; a zero product is neutral.
REQ-022 mac_tlast SHALL be s_tvalid[grant_id] AND s_tlast[grant_id] in STREAM, and 0 in all other states.
REQ-023 A transfer with tlast SHALL move the FSM to WAIT_DONE.
REQ-024 WAIT_DONE: on mac_done=1, SHALL capture mac_result into res_data and grant_id into res_id, and enter RESULT.
REQ-025 RESULT: SHALL hold res_valid=1 with stable data until res_ready=1, then update priority and return to IDLE.
REQ-026 The earliest next grant SHALL occur in the cycle after the res_valid/res_ready handshake.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Deassertion of auth_done mid-job SHALL NOT abort the job; it only blocks the next grant.
REQ-029 Arithmetic is performed entirely in the MAC; this block SHALL perform no width conversion beyond passing 2*WIDTH through.

Reset
REQ-030 On rst_n=0, the FSM SHALL enter IDLE and all outputs SHALL be 0; the priority pointer SHALL reset to N_REQ-1.
REQ-031 Reset mid-job SHALL discard the job with no res_valid; the MAC shares rst_n and is cleared in the same cycle.

Configuration
REQ-032 With MAC_ARB_WDOG_EN defined, the block SHALL count consecutive STREAM cycles with no valid beat.
REQ-033 With MAC_ARB_WDOG_EN defined, reaching WDOG_CYC SHALL force one mac_tlast with zero operands and set res_err=1 for that result.
REQ-034 With MAC_ARB_WDOG_EN defined, the counter SHALL clear on any valid beat.
REQ-035 Without MAC_ARB_WDOG_EN, no counter SHALL be present, res_err SHALL be tied 0, and STREAM waits indefinitely.

Structure
REQ-036 Package mac_arb_pkg SHALL hold the FSM state enum, the ID-width constant function and the default WDOG_CYC.
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter (req vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-038 Single requester 0, auth_done=1, beats (2,3),(4,5),(1,7)+tlast -> res_data=33, res_id=0, one mac_start pulse.
REQ-039 Requesters 0,1,2 all valid continuously -> grant order 0,1,2,0; no overlap of s_tready bits.
REQ-040 Requester 1 drops s_tvalid for 3 cycles mid-stream, beats (10,10),(1,1)+tlast -> res_data=101; gaps drive zero operands.
REQ-041 res_ready held low 5 cycles -> res_valid and res_data stable; no new grant until the handshake.
REQ-042 auth_done=0 with requests pending -> busy=0 and no mac_start; raising auth_done -> grant in the next cycle.
REQ-043 With MAC_ARB_WDOG_EN and WDOG_CYC=8, a stream that stalls after beat (3,3) -> res_data=9, res_err=1. Separately, rst_n asserted in STREAM -> all outputs 0 the next cycle.
